// File: rtl/bitwise_op_unit_pkg.sv
// Shared types and the bitwise evaluation function for the bitwise_op_unit slice.
// Operands are zero-extended to MAX_W inside bitop_eval, so WIDTH may not exceed MAX_W.
package bitop_pkg;

   typedef enum logic [1:0] {
      OP_XOR = 2'd0,
      OP_OR  = 2'd1,
      OP_AND = 2'd2,
      OP_NOT = 2'd3
   } op_e;

   localparam int OP_W  = 2;
   localparam int MAX_W = 64;

   function automatic logic [MAX_W-1:0] bitop_eval(input op_e op,
                                                  input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
      logic [MAX_W-1:0] r;
      r = '0;
      case (op)
         OP_XOR:  r = a ^ b;
         OP_OR:   r = a | b;
         OP_AND:  r = a & b;
         OP_NOT:  r = ~a;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bitwise_op_unit_if.sv
// Handshake bundle between a stimulus source/result sink (master) and bitwise_op_unit (slave).
// chg_cnt exists only when BITOP_CHG_CNT_EN is defined.
interface bitwise_op_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   import bitop_pkg::*;

   logic             in_valid;
   logic             in_ready;
   op_e              op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] z;
   logic             z_changed;

`ifdef BITOP_CHG_CNT_EN
   logic [CNT_W-1:0] chg_cnt;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, z, z_changed, chg_cnt
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, z, z_changed, chg_cnt
   );
`else
   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, z, z_changed
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, z, z_changed
   );
`endif

endinterface

// File: rtl/bitwise_op_unit_core.sv
// Purely combinational op/a/b -> result datapath of bitwise_op_unit.
module bitop_core
   import bitop_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result
);

   assign result = WIDTH'(bitop_eval(op, MAX_W'(a), MAX_W'(b)));

endmodule

// File: rtl/bitwise_op_unit.sv
// One-entry registered bitwise unit with valid/ready handshakes and a result-change strobe.
// Define BITOP_CHG_CNT_EN to add the saturating chg_cnt counter.
module bitwise_op_unit
   import bitop_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   bitwise_op_unit_if.slave bus
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] z_q;
   logic             z_changed_q;
   logic             accept;
   logic             changed;

   bitop_core #(.WIDTH(WIDTH)) u_core (
      .op     (bus.op),
      .a      (bus.a),
      .b      (bus.b),
      .result (result)
   );

   // The held word may retire and be replaced on the same edge, so ready looks through out_ready.
   assign bus.in_ready  = (state == ST_EMPTY) | bus.out_ready;
   assign bus.out_valid = (state == ST_FULL);
   assign accept        = bus.in_valid & bus.in_ready;
   assign changed       = (result != z_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_EMPTY;
         z_q         <= '0;
         z_changed_q <= 1'b0;
      end else begin
         z_changed_q <= accept & changed;
         if (accept) begin
            state <= ST_FULL;
            z_q   <= result;
         end else if (bus.out_ready) begin
            state <= ST_EMPTY;
         end
      end
   end

   assign bus.z         = z_q;
   assign bus.z_changed = z_changed_q;

`ifdef BITOP_CHG_CNT_EN
   logic [CNT_W-1:0] chg_cnt_q;

   // Counts on the same edge that raises z_changed so both are visible together.
   always_ff @(posedge clk) begin
      if (rst) begin
         chg_cnt_q <= '0;
      end else if (accept && changed && (chg_cnt_q != {CNT_W{1'b1}})) begin
         chg_cnt_q <= chg_cnt_q + CNT_W'(1);
      end
   end

   assign bus.chg_cnt = chg_cnt_q;
`endif

endmodule
